vcve2_branch_predict_ctrl: RTL and testbench

- Sequences the static branch predictor between fetch and execute.
- Accepts each predicted branch/jump as ID issues it, drives the registered fetch redirect for predicted-taken instructions, and tracks in-flight predictions in an in-order queue.
- Checks each execute-stage resolution against the oldest queued prediction. On mismatch it raises a flush and redirects fetch to the correct PC.
- A global enable configures the predictor off, giving pure fall-through fetch.

---
 rtl/vcve2_branch_predict_ctrl_pkg.sv | 29 ++
 rtl/vcve2_branch_predict_ctrl_if.sv | 31 +++
 rtl/vcve2_branch_predict_ctrl_fifo.sv | 72 +++++++
 rtl/vcve2_branch_predict_ctrl.sv | 154 +++++++++++++++
 tb/tb_vcve2_branch_predict_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vcve2_branch_predict_ctrl_pkg.sv
// Shared types and constants for the static branch predictor controller.
package vcve2_branch_predict_ctrl_pkg;

    typedef enum logic [0:0] {
        BP_IDLE  = 1'b0,
        BP_FLUSH = 1'b1
    } bp_ctrl_state_e;

    typedef struct packed {
        logic [31:0] exp_pc;
        logic        taken;
    } bp_entry_t;

    localparam logic [31:0] BP_PC_INC_RVC = 32'd2;
    localparam logic [31:0] BP_PC_INC_RV  = 32'd4;

    // Next PC the predictor expects EX to resolve to (32-bit wrapping add).
    function automatic logic [31:0] bp_exp_pc(
        input logic        taken,
        input logic [31:0] target,
        input logic [31:0] pc,
        input logic        compressed
    );
        logic [31:0] inc;
        inc = compressed ? BP_PC_INC_RVC : BP_PC_INC_RV;
        return taken ? target : (pc + inc);
    endfunction

endpackage

// File: rtl/vcve2_branch_predict_ctrl_if.sv
// ID/EX/fetch-facing signal bundle of the branch predictor controller.
interface vcve2_branch_predict_ctrl_if;
    logic        bp_enable_i;
    logic        pred_valid_i;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;
    logic [31:0] pred_pc_i;
    logic        pred_compressed_i;
    logic        pred_ready_o;
    logic        resolve_valid_i;
    logic [31:0] resolve_next_pc_i;
    logic        fetch_redirect_o;
    logic [31:0] fetch_redirect_pc_o;
    logic        flush_o;
    logic        busy_o;
    logic        resolve_err_o;

    modport master (
        output bp_enable_i, pred_valid_i, pred_taken_i, pred_target_i, pred_pc_i,
               pred_compressed_i, resolve_valid_i, resolve_next_pc_i,
        input  pred_ready_o, fetch_redirect_o, fetch_redirect_pc_o, flush_o,
               busy_o, resolve_err_o
    );

    modport slave (
        input  bp_enable_i, pred_valid_i, pred_taken_i, pred_target_i, pred_pc_i,
               pred_compressed_i, resolve_valid_i, resolve_next_pc_i,
        output pred_ready_o, fetch_redirect_o, fetch_redirect_pc_o, flush_o,
               busy_o, resolve_err_o
    );
endinterface

// File: rtl/vcve2_branch_predict_ctrl_fifo.sv
// In-order queue of in-flight predictions; clear takes priority over push/pop.
module vcve2_bp_fifo
    import vcve2_branch_predict_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  bp_entry_t        push_data_i,
    output bp_entry_t        head_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    bp_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    // Pointer and occupancy update; DEPTH is a power of 2 so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = (PTR_W+1)'(0);
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= (PTR_W+1)'(0);
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !clear_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == (PTR_W+1)'(0));

endmodule

// File: rtl/vcve2_branch_predict_ctrl.sv
// Static branch predictor sequencer: predicted redirects, resolve checking, mispredict flush.
// Optional macro VCVE2_BP_PERF_COUNTERS_EN adds saturating branch/mispredict counters.
module vcve2_branch_predict_ctrl
    import vcve2_branch_predict_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
`ifdef VCVE2_BP_PERF_COUNTERS_EN
    output logic [31:0] perf_branches_o,
    output logic [31:0] perf_mispredicts_o,
`endif
    vcve2_branch_predict_ctrl_if.slave bp_if
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    bp_ctrl_state_e  state_q, state_d;
    bp_entry_t       enq_entry_s, head_s, resolved_s;
    logic [PTR_W:0]  count_s;
    logic            fifo_full_s, fifo_empty_s;
    logic            accept_s, enq_taken_s, resolve_act_s, mismatch_s, push_s, pop_s;
    logic            pred_ready_s, busy_s;
    logic            redirect_q, redirect_d;
    logic [31:0]     redirect_pc_q, redirect_pc_d;
    logic            flush_q, flush_d;
    logic            err_q, err_d;

    vcve2_bp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .clear_i     (mismatch_s),
        .push_data_i (enq_entry_s),
        .head_o      (head_s),
        .count_o     (count_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Datapath: enqueue entry, resolve compare and next values of the registered outputs.
    always_comb begin
        enq_taken_s        = bp_if.bp_enable_i & bp_if.pred_taken_i;
        enq_entry_s.exp_pc = bp_exp_pc(enq_taken_s, bp_if.pred_target_i, bp_if.pred_pc_i,
                                       bp_if.pred_compressed_i);
        enq_entry_s.taken  = enq_taken_s;
        accept_s           = bp_if.pred_valid_i & pred_ready_s;
        resolve_act_s      = bp_if.resolve_valid_i & ~fifo_empty_s;
        resolved_s.exp_pc  = bp_if.resolve_next_pc_i;
        resolved_s.taken   = head_s.taken;
        mismatch_s         = resolve_act_s & (resolved_s != head_s);
        // A mispredict clears the queue, so the same-cycle push is dropped with it.
        push_s             = accept_s & ~mismatch_s;
        pop_s              = resolve_act_s & ~mismatch_s;
        redirect_d         = mismatch_s | (accept_s & enq_taken_s);
        if (mismatch_s) begin
            redirect_pc_d = bp_if.resolve_next_pc_i;
        end else if (accept_s && enq_taken_s) begin
            redirect_pc_d = bp_if.pred_target_i;
        end else begin
            redirect_pc_d = 32'h0000_0000;
        end
        flush_d = mismatch_s;
        err_d   = err_q | (bp_if.resolve_valid_i & fifo_empty_s);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BP_IDLE:  state_d = mismatch_s ? BP_FLUSH : BP_IDLE;
            BP_FLUSH: state_d = BP_IDLE;
            default:  state_d = BP_IDLE;
        endcase
    end

    // State-dependent outputs.
    always_comb begin
        pred_ready_s = 1'b0;
        busy_s       = 1'b1;
        case (state_q)
            BP_IDLE: begin
                pred_ready_s = ~fifo_full_s;
                busy_s       = (count_s != (PTR_W+1)'(0));
            end
            BP_FLUSH: begin
                pred_ready_s = 1'b0;
                busy_s       = 1'b1;
            end
            default: begin
                pred_ready_s = 1'b0;
                busy_s       = 1'b1;
            end
        endcase
    end

    // State and registered output flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= BP_IDLE;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0000_0000;
            flush_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            err_q         <= err_d;
        end
    end

    assign bp_if.pred_ready_o        = pred_ready_s;
    assign bp_if.busy_o              = busy_s;
    assign bp_if.fetch_redirect_o    = redirect_q;
    assign bp_if.fetch_redirect_pc_o = redirect_pc_q;
    assign bp_if.flush_o             = flush_q;
    assign bp_if.resolve_err_o       = err_q;

`ifdef VCVE2_BP_PERF_COUNTERS_EN
    logic [31:0] perf_br_q, perf_br_d, perf_mis_q, perf_mis_d;

    // Saturating event counters.
    always_comb begin
        if (accept_s && (perf_br_q != 32'hFFFF_FFFF)) begin
            perf_br_d = perf_br_q + 32'd1;
        end else begin
            perf_br_d = perf_br_q;
        end
        if (mismatch_s && (perf_mis_q != 32'hFFFF_FFFF)) begin
            perf_mis_d = perf_mis_q + 32'd1;
        end else begin
            perf_mis_d = perf_mis_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_br_q  <= 32'h0000_0000;
            perf_mis_q <= 32'h0000_0000;
        end else begin
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_branches_o    = perf_br_q;
    assign perf_mispredicts_o = perf_mis_q;
`endif

endmodule

// File: tb/tb_vcve2_branch_predict_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_vcve2_branch_predict_ctrl;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vcve2_branch_predict_ctrl_if bp_if();

`ifdef VCVE2_BP_PERF_COUNTERS_EN
    logic [31:0] perf_br, perf_mis;
    vcve2_branch_predict_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .perf_branches_o(perf_br), .perf_mispredicts_o(perf_mis),
        .bp_if(bp_if));
`else
    vcve2_branch_predict_ctrl #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bp_if(bp_if));
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: queue of expected next PCs plus flush/err flags.
    logic [31:0] mq[$];
    bit          m_flushing, m_err, e_redir, e_flush;
    logic [31:0] e_pc;
    int          m_branches, m_mis;

    task automatic model_reset();
        mq.delete();
        m_flushing = 0; m_err = 0; e_redir = 0; e_flush = 0; e_pc = 32'h0;
        m_branches = 0; m_mis = 0;
    endtask

    task automatic idle_inputs();
        bp_if.pred_valid_i      = 1'b0;
        bp_if.pred_taken_i      = 1'b0;
        bp_if.pred_compressed_i = 1'b0;
        bp_if.pred_pc_i         = 32'h0;
        bp_if.pred_target_i     = 32'h0;
        bp_if.resolve_valid_i   = 1'b0;
        bp_if.resolve_next_pc_i = 32'h0;
    endtask

    task automatic drive_pred(input bit t, input logic [31:0] pc, input logic [31:0] tgt, input bit c);
        bp_if.pred_valid_i = 1'b1; bp_if.pred_taken_i = t;
        bp_if.pred_pc_i = pc; bp_if.pred_target_i = tgt; bp_if.pred_compressed_i = c;
    endtask

    task automatic drive_res(input logic [31:0] pc);
        bp_if.resolve_valid_i = 1'b1; bp_if.resolve_next_pc_i = pc;
    endtask

    // Advance the model with the current inputs, then clock the DUT once.
    task automatic cycle();
        bit ready, acc, res, mis, etaken;
        logic [31:0] exp;
        ready  = !m_flushing && (mq.size() < DEPTH);
        acc    = bp_if.pred_valid_i && ready;
        etaken = bp_if.bp_enable_i && bp_if.pred_taken_i;
        exp    = etaken ? bp_if.pred_target_i
                        : bp_if.pred_pc_i + (bp_if.pred_compressed_i ? 32'd2 : 32'd4);
        res    = bp_if.resolve_valid_i && (mq.size() > 0);
        mis    = res && (bp_if.resolve_next_pc_i != mq[0]);
        if (bp_if.resolve_valid_i && mq.size() == 0) m_err = 1;
        e_flush = mis;
        e_redir = mis || (acc && etaken);
        e_pc    = mis ? bp_if.resolve_next_pc_i : ((acc && etaken) ? bp_if.pred_target_i : 32'h0);
        if (acc) m_branches++;
        if (mis) begin
            mq.delete(); m_flushing = 1; m_mis++;
        end else begin
            m_flushing = 0;
            if (res) void'(mq.pop_front());
            if (acc) mq.push_back(exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bp_if.fetch_redirect_o, bp_if.flush_o, bp_if.busy_o, bp_if.resolve_err_o} !== 4'b0000
            || bp_if.fetch_redirect_pc_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got redir=%b pc=%h flush=%b busy=%b err=%b want all 0",
                     bp_if.fetch_redirect_o, bp_if.fetch_redirect_pc_o, bp_if.flush_o,
                     bp_if.busy_o, bp_if.resolve_err_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bp_if.pred_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b want 1", bp_if.pred_ready_o);
        end
    endtask

    task automatic test_mispredict();
        drive_pred(1'b1, 32'h100, 32'h0F0, 1'b0);
        cycle(); idle_inputs();
        total++;
        if (bp_if.fetch_redirect_o !== 1'b1 || bp_if.fetch_redirect_pc_o !== 32'h0F0) begin
            bad++; $display("FAIL mis_pred_redirect: got %b/%h want 1/000000f0",
                            bp_if.fetch_redirect_o, bp_if.fetch_redirect_pc_o);
        end
        drive_res(32'h104);
        cycle(); idle_inputs();
        total++;
        if ({bp_if.flush_o, bp_if.fetch_redirect_o, bp_if.busy_o, bp_if.pred_ready_o} !== 4'b1110
            || bp_if.fetch_redirect_pc_o !== 32'h104) begin
            bad++; $display("FAIL mis_flush: got flush=%b redir=%b busy=%b rdy=%b pc=%h want 1 1 1 0 00000104",
                            bp_if.flush_o, bp_if.fetch_redirect_o, bp_if.busy_o,
                            bp_if.pred_ready_o, bp_if.fetch_redirect_pc_o);
        end
        cycle();
        total++;
        if ({bp_if.busy_o, bp_if.pred_ready_o, bp_if.flush_o, bp_if.fetch_redirect_o} !== 4'b0100) begin
            bad++; $display("FAIL mis_after: got busy=%b rdy=%b flush=%b redir=%b want 0 1 0 0",
                            bp_if.busy_o, bp_if.pred_ready_o, bp_if.flush_o, bp_if.fetch_redirect_o);
        end
    endtask

    task automatic test_match();
        drive_pred(1'b0, 32'h200, 32'h0, 1'b1);
        cycle(); idle_inputs();
        total++;
        if (bp_if.fetch_redirect_o !== 1'b0 || bp_if.busy_o !== 1'b1) begin
            bad++; $display("FAIL match_accept: got redir=%b busy=%b want 0 1",
                            bp_if.fetch_redirect_o, bp_if.busy_o);
        end
        drive_res(32'h202);
        cycle(); idle_inputs();
        total++;
        if (bp_if.flush_o !== 1'b0 || bp_if.fetch_redirect_o !== 1'b0 || bp_if.busy_o !== 1'b0) begin
            bad++; $display("FAIL match_resolve: got flush=%b redir=%b busy=%b want 0 0 0",
                            bp_if.flush_o, bp_if.fetch_redirect_o, bp_if.busy_o);
        end
    endtask

    task automatic test_full();
        drive_pred(1'b0, 32'h300, 32'h0, 1'b0); cycle();
        drive_pred(1'b0, 32'h308, 32'h0, 1'b0); cycle(); idle_inputs();
        total++;
        if (bp_if.pred_ready_o !== 1'b0 || bp_if.busy_o !== 1'b1) begin
            bad++; $display("FAIL full_ready: got rdy=%b busy=%b want 0 1", bp_if.pred_ready_o, bp_if.busy_o);
        end
        drive_pred(1'b0, 32'h320, 32'h0, 1'b0); drive_res(32'h304);
        cycle(); idle_inputs();
        total++;
        if (bp_if.pred_ready_o !== 1'b1 || bp_if.flush_o !== 1'b0) begin
            bad++; $display("FAIL full_no_bypass: got rdy=%b flush=%b want 1 0", bp_if.pred_ready_o, bp_if.flush_o);
        end
        drive_pred(1'b0, 32'h310, 32'h0, 1'b0); drive_res(32'h30C);
        cycle(); idle_inputs();
        total++;
        if ({bp_if.pred_ready_o, bp_if.busy_o, bp_if.flush_o} !== 3'b110) begin
            bad++; $display("FAIL full_push_pop: got rdy=%b busy=%b flush=%b want 1 1 0",
                            bp_if.pred_ready_o, bp_if.busy_o, bp_if.flush_o);
        end
        drive_res(32'h314);
        cycle(); idle_inputs();
        total++;
        if (bp_if.busy_o !== 1'b0 || bp_if.flush_o !== 1'b0) begin
            bad++; $display("FAIL full_drain: got busy=%b flush=%b want 0 0", bp_if.busy_o, bp_if.flush_o);
        end
    endtask

    task automatic test_mis_concurrent();
        drive_pred(1'b1, 32'h400, 32'h500, 1'b0);
        cycle(); idle_inputs();
        drive_res(32'h480); drive_pred(1'b1, 32'h600, 32'h700, 1'b0);
        cycle(); idle_inputs();
        total++;
        if ({bp_if.flush_o, bp_if.fetch_redirect_o, bp_if.pred_ready_o} !== 3'b110
            || bp_if.fetch_redirect_pc_o !== 32'h480) begin
            bad++; $display("FAIL conc_redirect: got flush=%b redir=%b rdy=%b pc=%h want 1 1 0 00000480",
                            bp_if.flush_o, bp_if.fetch_redirect_o, bp_if.pred_ready_o,
                            bp_if.fetch_redirect_pc_o);
        end
        cycle();
        total++;
        if ({bp_if.busy_o, bp_if.pred_ready_o, bp_if.fetch_redirect_o} !== 3'b010) begin
            bad++; $display("FAIL conc_empty: got busy=%b rdy=%b redir=%b want 0 1 0",
                            bp_if.busy_o, bp_if.pred_ready_o, bp_if.fetch_redirect_o);
        end
    endtask

    task automatic test_disabled();
        bp_if.bp_enable_i = 1'b0;
        drive_pred(1'b1, 32'hFFFF_FFFC, 32'h80, 1'b0);
        cycle(); idle_inputs();
        total++;
        if (bp_if.fetch_redirect_o !== 1'b0 || bp_if.busy_o !== 1'b1) begin
            bad++; $display("FAIL dis_no_redirect: got redir=%b busy=%b want 0 1", bp_if.fetch_redirect_o, bp_if.busy_o);
        end
        drive_res(32'h80);
        cycle(); idle_inputs();
        total++;
        if (bp_if.flush_o !== 1'b1 || bp_if.fetch_redirect_pc_o !== 32'h80) begin
            bad++; $display("FAIL dis_flush: got flush=%b pc=%h want 1 00000080", bp_if.flush_o, bp_if.fetch_redirect_pc_o);
        end
        cycle();
        drive_pred(1'b1, 32'hFFFF_FFFC, 32'h80, 1'b0);
        cycle(); idle_inputs();
        drive_res(32'h0);
        cycle(); idle_inputs();
        total++;
        if (bp_if.flush_o !== 1'b0 || bp_if.busy_o !== 1'b0) begin
            bad++; $display("FAIL dis_wrap_match: got flush=%b busy=%b want 0 0", bp_if.flush_o, bp_if.busy_o);
        end
        bp_if.bp_enable_i = 1'b1;
    endtask

    task automatic test_err_reset();
        total++;
        if (bp_if.resolve_err_o !== 1'b0) begin
            bad++; $display("FAIL err_initial: got %b want 0", bp_if.resolve_err_o);
        end
        drive_res(32'h1234);
        cycle(); idle_inputs();
        cycle();
        total++;
        if (bp_if.resolve_err_o !== 1'b1 || bp_if.busy_o !== 1'b0) begin
            bad++; $display("FAIL err_sticky: got err=%b busy=%b want 1 0", bp_if.resolve_err_o, bp_if.busy_o);
        end
        drive_pred(1'b0, 32'h10, 32'h0, 1'b0); cycle();
        drive_pred(1'b1, 32'h20, 32'h40, 1'b0); cycle(); idle_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if ({bp_if.fetch_redirect_o, bp_if.flush_o, bp_if.busy_o, bp_if.resolve_err_o} !== 4'b0000
            || bp_if.fetch_redirect_pc_o !== 32'h0) begin
            bad++; $display("FAIL midop_reset: got redir=%b pc=%h flush=%b busy=%b err=%b want all 0",
                            bp_if.fetch_redirect_o, bp_if.fetch_redirect_pc_o, bp_if.flush_o,
                            bp_if.busy_o, bp_if.resolve_err_o);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bp_if.pred_ready_o !== 1'b1 || bp_if.busy_o !== 1'b0) begin
            bad++; $display("FAIL post_reset: got rdy=%b busy=%b want 1 0", bp_if.pred_ready_o, bp_if.busy_o);
        end
    endtask

    task automatic test_random();
        bit [4:0] got, want;
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            bp_if.bp_enable_i = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1)
                drive_pred($urandom_range(0, 1) == 1, {22'h0, $urandom_range(0, 255), 2'b00},
                           {22'h0, $urandom_range(0, 255), 2'b00}, $urandom_range(0, 1) == 1);
            if (mq.size() > 0 && $urandom_range(0, 2) != 0)
                drive_res(($urandom_range(0, 4) != 0) ? mq[0] : {22'h0, $urandom_range(0, 255), 2'b00});
            else if ($urandom_range(0, 30) == 0)
                drive_res(32'h8);
            cycle();
            got  = {bp_if.fetch_redirect_o, bp_if.flush_o, bp_if.resolve_err_o, bp_if.busy_o, bp_if.pred_ready_o};
            want = {e_redir, e_flush, m_err, (mq.size() > 0) || m_flushing,
                    !m_flushing && (mq.size() < DEPTH)};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL rand_ctrl[%0d]: got redir,flush,err,busy,rdy=%b want %b", n, got, want);
            end
            if (e_redir) begin
                total++;
                if (bp_if.fetch_redirect_pc_o !== e_pc) begin
                    bad++; $display("FAIL rand_pc[%0d]: got %h want %h", n, bp_if.fetch_redirect_pc_o, e_pc);
                end
            end
        end
        idle_inputs();
`ifdef VCVE2_BP_PERF_COUNTERS_EN
        total++;
        if (perf_br !== 32'(m_branches) || perf_mis !== 32'(m_mis)) begin
            bad++; $display("FAIL perf_counts: got %0d/%0d want %0d/%0d", perf_br, perf_mis, m_branches, m_mis);
        end
`endif
    endtask

    initial begin
        bp_if.bp_enable_i = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_mispredict();
        test_match();
        test_full();
        test_mis_concurrent();
        test_disabled();
        test_err_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
